// File: rtl/rc4_pkg.sv
// Shared RC4 cracker definitions: byte type, memory sizes and PRGA state encoding.
package rc4_pkg;

   localparam int unsigned MSG_LEN = 32;
   localparam int unsigned AW_MSG  = 5;
   localparam int unsigned S_DEPTH = 256;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned K_W     = 6;

   typedef logic [BYTE_W-1:0] byte_t;

   typedef enum logic [3:0] {
      IDLE,
      RD_I,
      WT_I,
      RD_J,
      WT_J,
      WR_I,
      WR_J,
      RD_F,
      WT_F,
      WR_DEC,
      OFFER,
      NEXT,
      DONE
   } prga_state_t;

endpackage

// File: rtl/prga_char_producer.sv
// RC4 PRGA stage: decrypts the encrypted message through the S memory, writes DM
// and offers each character to the key checker over new_char/char_compare.
module prga_char_producer
   import rc4_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start_flag,
   output logic              done_flag,
   output logic [7:0]        addr,
   input  logic [7:0]        rddata,
   output logic [7:0]        wrdata,
   output logic              wren,
   output logic [AW_MSG-1:0] addr_enc,
   input  logic [7:0]        rddata_enc,
   output logic [AW_MSG-1:0] addr_dec,
   output logic [7:0]        wrdata_dec,
   output logic              wren_dec,
   output logic [K_W-1:0]    k,
   output logic              new_char,
   input  logic              char_compare,
   output logic [7:0]        data_xord,
   input  logic              start_over
);

   prga_state_t state, state_d;

   byte_t i, j, si, sj, enc_q;
   byte_t i_d, j_d, si_d, sj_d, enc_d;
   logic [K_W-1:0] k_d;

   byte_t             addr_d, wrdata_d, wrdata_dec_d, data_xord_d;
   logic [AW_MSG-1:0] addr_enc_d, addr_dec_d;
   logic              wren_d, wren_dec_d, new_char_d, done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         i          <= '0;
         j          <= '0;
         k          <= '0;
         si         <= '0;
         sj         <= '0;
         enc_q      <= '0;
         addr       <= '0;
         wrdata     <= '0;
         wren       <= 1'b0;
         addr_enc   <= '0;
         addr_dec   <= '0;
         wrdata_dec <= '0;
         wren_dec   <= 1'b0;
         new_char   <= 1'b0;
         data_xord  <= '0;
         done_flag  <= 1'b0;
      end else begin
         state      <= state_d;
         i          <= i_d;
         j          <= j_d;
         k          <= k_d;
         si         <= si_d;
         sj         <= sj_d;
         enc_q      <= enc_d;
         addr       <= addr_d;
         wrdata     <= wrdata_d;
         wren       <= wren_d;
         addr_enc   <= addr_enc_d;
         addr_dec   <= addr_dec_d;
         wrdata_dec <= wrdata_dec_d;
         wren_dec   <= wren_dec_d;
         new_char   <= new_char_d;
         data_xord  <= data_xord_d;
         done_flag  <= done_d;
      end
   end

   always_comb begin
      state_d      = state;
      i_d          = i;
      j_d          = j;
      k_d          = k;
      si_d         = si;
      sj_d         = sj;
      enc_d        = enc_q;
      addr_d       = addr;
      wrdata_d     = wrdata;
      wren_d       = 1'b0;
      addr_enc_d   = addr_enc;
      addr_dec_d   = addr_dec;
      wrdata_dec_d = wrdata_dec;
      wren_dec_d   = 1'b0;
      new_char_d   = 1'b0;
      data_xord_d  = data_xord;
      done_d       = 1'b0;

      // Sequencing and datapath updates for the current state.
      unique case (state)
         IDLE:   if (start_flag) state_d = RD_I;
         RD_I:   state_d = WT_I;
         WT_I: begin
            i_d     = i + 8'd1;
            si_d    = rddata;
            j_d     = j + rddata;
            enc_d   = rddata_enc;
            state_d = RD_J;
         end
         RD_J:   state_d = WT_J;
         WT_J: begin
            sj_d    = rddata;
            state_d = WR_I;
         end
         WR_I:   state_d = WR_J;
         WR_J:   state_d = RD_F;
         RD_F:   state_d = WT_F;
         WT_F:   state_d = WR_DEC;
         WR_DEC: state_d = OFFER;
         OFFER:  if (char_compare) state_d = NEXT;
         NEXT: begin
            if (k == K_W'(MSG_LEN - 1)) begin
               state_d = DONE;
            end else begin
               k_d     = k + 6'd1;
               state_d = RD_I;
            end
         end
         DONE:   state_d = DONE;
         default: state_d = IDLE;
      endcase

      // Checker abort overrides every transition, including a same-cycle ack.
      if (start_over) begin
         state_d = IDLE;
         i_d     = '0;
         j_d     = '0;
         k_d     = '0;
      end

      // Outputs are registered for the state being entered, so memory addresses
      // are on the bus for the whole of the issuing state.
      unique case (state_d)
         RD_I: begin
            addr_d     = i_d + 8'd1;
            addr_enc_d = AW_MSG'(k_d);
         end
         RD_J:   addr_d = j_d;
         WR_I: begin
            addr_d   = i_d;
            wrdata_d = sj_d;
            wren_d   = 1'b1;
         end
         WR_J: begin
            addr_d   = j_d;
            wrdata_d = si_d;
            wren_d   = 1'b1;
         end
         RD_F:   addr_d = si_d + sj_d;
         WR_DEC: begin
            addr_dec_d   = AW_MSG'(k_d);
            wrdata_dec_d = rddata ^ enc_d;
            data_xord_d  = rddata ^ enc_d;
            wren_dec_d   = 1'b1;
         end
         OFFER:  new_char_d = 1'b1;
         DONE:   done_d     = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_prga_char_producer.sv
// Directed bench for prga_char_producer with behavioural S/EM/DM memories
// and an independent RC4 PRGA reference model.
module tb_prga_char_producer;
   import rc4_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              start_flag;
   logic              done_flag;
   logic [7:0]        addr;
   logic [7:0]        rddata;
   logic [7:0]        wrdata;
   logic              wren;
   logic [AW_MSG-1:0] addr_enc;
   logic [7:0]        rddata_enc;
   logic [AW_MSG-1:0] addr_dec;
   logic [7:0]        wrdata_dec;
   logic              wren_dec;
   logic [K_W-1:0]    k;
   logic              new_char;
   logic              char_compare;
   logic [7:0]        data_xord;
   logic              start_over;

   int errors = 0;
   int checks = 0;

   logic [7:0] smem [256];
   logic [7:0] em   [32];
   logic [AW_MSG-1:0] dec_log [64];
   int   dec_cnt;
   int   wr_cnt;
   logic s_init;
   logic cnt_clr;

   logic [7:0] ms [256];
   logic [7:0] mi, mj;

   prga_char_producer dut (
      .clk(clk), .reset(reset), .start_flag(start_flag), .done_flag(done_flag),
      .addr(addr), .rddata(rddata), .wrdata(wrdata), .wren(wren),
      .addr_enc(addr_enc), .rddata_enc(rddata_enc),
      .addr_dec(addr_dec), .wrdata_dec(wrdata_dec), .wren_dec(wren_dec),
      .k(k), .new_char(new_char), .char_compare(char_compare),
      .data_xord(data_xord), .start_over(start_over)
   );

   always #5 clk = ~clk;

   // S, EM and DM memories with one-cycle synchronous reads.
   always @(posedge clk) begin
      if (s_init) begin
         for (int x = 0; x < 256; x++) smem[x] <= 8'(x);
      end else if (wren) begin
         smem[addr] <= wrdata;
      end
      rddata     <= smem[addr];
      rddata_enc <= em[addr_enc];
      if (cnt_clr) begin
         dec_cnt <= 0;
         wr_cnt  <= 0;
      end else begin
         if (wren_dec && dec_cnt < 64) begin
            dec_log[dec_cnt] <= addr_dec;
            dec_cnt <= dec_cnt + 1;
         end
         if (wren) wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic model_init();
      for (int x = 0; x < 256; x++) ms[x] = 8'(x);
      mi = 8'd0;
      mj = 8'd0;
   endtask

   task automatic model_step(input logic [7:0] enc, output logic [7:0] dec);
      logic [7:0] a, b;
      mi = mi + 8'd1;
      a  = ms[mi];
      mj = mj + a;
      b  = ms[mj];
      ms[mi] = b;
      ms[mj] = a;
      dec = ms[8'(a + b)] ^ enc;
   endtask

   task automatic wait_new_char();
      int n = 0;
      while (!new_char && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic ack();
      char_compare = 1'b1;
      @(negedge clk);
      char_compare = 1'b0;
   endtask

   task automatic fresh_start(input logic keep_start);
      @(negedge clk);
      reset   = 1'b1;
      s_init  = 1'b1;
      cnt_clr = 1'b1;
      @(negedge clk);
      reset      = 1'b0;
      s_init     = 1'b0;
      cnt_clr    = 1'b0;
      start_flag = 1'b1;
      model_init();
      @(negedge clk);
      start_flag = keep_start;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({done_flag, addr, wrdata, wren, addr_enc, addr_dec, wrdata_dec,
           wren_dec, k, new_char, data_xord} !== '0)
         begin errors++; $display("FAIL reset_outputs: got nonzero output, required all 0 (addr=%h k=%0d)", addr, k); end
   endtask

   task automatic test_identity();
      for (int x = 0; x < 32; x++) em[x] = 8'h00;
      fresh_start(1'b0);
      wait_new_char();
      checks++;
      if (!new_char || data_xord !== 8'h02 || k !== 6'd0)
         begin errors++; $display("FAIL ident_char0: data_xord=%h k=%0d nc=%b, required 02 k=0", data_xord, k, new_char); end
      ack();
      wait_new_char();
      checks++;
      if (!new_char || data_xord !== 8'h05 || k !== 6'd1)
         begin errors++; $display("FAIL ident_char1: data_xord=%h k=%0d nc=%b, required 05 k=1", data_xord, k, new_char); end
      checks++;
      if (smem[2] !== 8'h03 || smem[3] !== 8'h02)
         begin errors++; $display("FAIL ident_swap: S[2]=%h S[3]=%h, required 03 02", smem[2], smem[3]); end
      ack();
   endtask

   task automatic test_hold();
      logic stable;
      for (int x = 0; x < 32; x++) em[x] = 8'h00;
      em[0] = 8'h41;
      fresh_start(1'b0);
      wait_new_char();
      checks++;
      if (!new_char || data_xord !== 8'h43 || k !== 6'd0)
         begin errors++; $display("FAIL hold_char0: data_xord=%h k=%0d nc=%b, required 43 k=0", data_xord, k, new_char); end
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!new_char || data_xord !== 8'h43 || k !== 6'd0) stable = 1'b0;
      end
      checks++;
      if (!stable)
         begin errors++; $display("FAIL hold_stable: offer changed while unacked, now nc=%b data_xord=%h", new_char, data_xord); end
      ack();
      checks++;
      if (new_char !== 1'b0)
         begin errors++; $display("FAIL hold_drop: new_char=%b after ack, required 0", new_char); end
   endtask

   task automatic test_full_pass();
      logic [7:0] e;
      logic ok;
      int n;
      for (int x = 0; x < 32; x++) em[x] = 8'(x * 7 + 1);
      fresh_start(1'b0);
      for (int c = 0; c < 32; c++) begin
         model_step(em[c], e);
         wait_new_char();
         checks++;
         if (!new_char || data_xord !== e || k !== 6'(c))
            begin errors++; $display("FAIL full_char%0d: data_xord=%h k=%0d nc=%b, required %h", c, data_xord, k, new_char, e); end
         ack();
      end
      n = 0;
      while (!done_flag && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (done_flag !== 1'b1)
         begin errors++; $display("FAIL full_done: done_flag=%b, required 1", done_flag); end
      ok = 1'b1;
      repeat (10) begin @(negedge clk); if (done_flag !== 1'b1 || wren_dec !== 1'b0) ok = 1'b0; end
      checks++;
      if (!ok)
         begin errors++; $display("FAIL full_done_hold: done_flag=%b wren_dec=%b, required held 1 / 0", done_flag, wren_dec); end
      checks++;
      if (dec_cnt !== 32)
         begin errors++; $display("FAIL full_dec_count: %0d wren_dec pulses, required 32", dec_cnt); end
      for (int c = 0; c < 32; c++) begin
         checks++;
         if (dec_log[c] !== AW_MSG'(c))
            begin errors++; $display("FAIL full_addr_dec%0d: got %0d, required %0d", c, dec_log[c], c); end
      end
   endtask

   task automatic test_abort();
      logic [7:0] e;
      int n;
      for (int x = 0; x < 32; x++) em[x] = 8'(x) ^ 8'h5a;
      fresh_start(1'b1);
      for (int c = 0; c < 7; c++) begin
         model_step(em[c], e);
         wait_new_char();
         checks++;
         if (!new_char || data_xord !== e || k !== 6'(c))
            begin errors++; $display("FAIL abort_char%0d: data_xord=%h k=%0d, required %h", c, data_xord, k, e); end
         ack();
      end
      n = 0;
      while (dut.state !== WT_J && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (dut.state !== WT_J || k !== 6'd7)
         begin errors++; $display("FAIL abort_reach_wtj: state=%0d k=%0d, required WT_J k=7", dut.state, k); end
      start_over = 1'b1;
      @(negedge clk);
      start_over = 1'b0;
      checks++;
      if (dut.state !== IDLE || wren !== 1'b0 || k !== 6'd0 || new_char !== 1'b0)
         begin errors++; $display("FAIL abort_idle: state=%0d wren=%b k=%0d, required IDLE 0 0", dut.state, wren, k); end
      mi = 8'd0;
      mj = 8'd0;
      model_step(em[0], e);
      wait_new_char();
      checks++;
      if (!new_char || data_xord !== e || k !== 6'd0)
         begin errors++; $display("FAIL abort_restart: data_xord=%h k=%0d, required %h k=0", data_xord, k, e); end
      start_flag = 1'b0;
      ack();
   endtask

   task automatic test_abort_vs_ack();
      for (int x = 0; x < 32; x++) em[x] = 8'h00;
      fresh_start(1'b0);
      wait_new_char();
      ack();
      wait_new_char();
      checks++;
      if (!new_char || k !== 6'd1 || data_xord !== 8'h05)
         begin errors++; $display("FAIL race_offer: k=%0d data_xord=%h, required k=1 05", k, data_xord); end
      char_compare = 1'b1;
      start_over   = 1'b1;
      @(negedge clk);
      char_compare = 1'b0;
      start_over   = 1'b0;
      checks++;
      if (dut.state !== IDLE || k !== 6'd0 || new_char !== 1'b0)
         begin errors++; $display("FAIL race_idle: state=%0d k=%0d nc=%b, required IDLE 0 0", dut.state, k, new_char); end
      repeat (3) @(negedge clk);
      checks++;
      if (dut.state !== IDLE || wren !== 1'b0 || wren_dec !== 1'b0 || k !== 6'd0)
         begin errors++; $display("FAIL race_stay_idle: state=%0d wren=%b k=%0d, required IDLE 0 0", dut.state, wren, k); end
   endtask

   task automatic test_reset_mid_write();
      int n;
      for (int x = 0; x < 32; x++) em[x] = 8'h00;
      fresh_start(1'b0);
      n = 0;
      while (wren !== 1'b1 && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (wren !== 1'b1 || dut.state !== WR_I)
         begin errors++; $display("FAIL rst_reach_wri: wren=%b state=%0d, required 1 WR_I", wren, dut.state); end
      reset = 1'b1;
      #1;
      checks++;
      if ({done_flag, addr, wrdata, wren, addr_enc, addr_dec, wrdata_dec,
           wren_dec, k, new_char, data_xord} !== '0)
         begin errors++; $display("FAIL rst_async: outputs nonzero (wren=%b addr=%h), required all 0", wren, addr); end
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (wr_cnt !== 0)
         begin errors++; $display("FAIL rst_no_write: %0d S writes after reset, required 0", wr_cnt); end
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      start_flag   = 1'b0;
      char_compare = 1'b0;
      start_over   = 1'b0;
      s_init       = 1'b1;
      cnt_clr      = 1'b1;
      for (int x = 0; x < 32; x++) em[x] = 8'h00;
      model_init();
      test_reset();
      test_identity();
      test_hold();
      test_full_pass();
      test_abort();
      test_abort_vs_ack();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
